// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_pkg
//  Description : Shared Ethernet framing constants, framer state encoding and
//                a byte-wide reflected CRC32 step function.
//  Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WAITDATA = 4'd1,
        ST_PREAMBLE = 4'd2,
        ST_SFD      = 4'd3,
        ST_HEADER   = 4'd4,
        ST_PAYLOAD  = 4'd5,
        ST_PAD      = 4'd6,
        ST_FCS      = 4'd7,
        ST_IFG      = 4'd8
    } state_e;

    localparam logic [7:0]  ETHPREAMBLE    = 8'h55;
    localparam logic [7:0]  ETHSFD         = 8'hD5;
    localparam logic [31:0] CRC32POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC32INIT      = 32'hFFFFFFFF;
    localparam int          ETHPREAMBLELEN = 7;
    localparam int          ETHHEADLEN     = 14;
    localparam int          ETHMINPAYLOAD  = 46;
    localparam int          ETHFCSLEN      = 4;

    // One byte through the LSB-first CRC32 shift register.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_tx_framer_if.sv
`default_nettype none
// ============================================================================
//  Module      : eth_tx_framer_if
//  Description : Client handshake/payload bus and GMII transmit outputs of the
//                Ethernet transmit framer.
//                master : client side (drives request/dven/data/err/addresses)
//                slave  : framer side (drives ack, txd/txen/txer, busy)
//  Revision    : 1.0 - initial release
// ============================================================================
interface eth_tx_framer_if;
    logic        request;
    logic        ack;
    logic        dven;
    logic [7:0]  data;
    logic        err;
    logic [47:0] smac;
    logic [47:0] dmac;
    logic [15:0] ethertype;
    logic [7:0]  txd;
    logic        txen;
    logic        txer;
    logic        busy;

    modport master (
        output request, dven, data, err, smac, dmac, ethertype,
        input  ack, txd, txen, txer, busy
    );

    modport slave (
        input  request, dven, data, err, smac, dmac, ethertype,
        output ack, txd, txen, txer, busy
    );
endinterface
`default_nettype wire

// File: rtl/crc32_d8.sv
`default_nettype none
// ============================================================================
//  Module      : crc32_d8
//  Description : Byte-serial Ethernet CRC32 accumulator (reflected, init all
//                ones, no output inversion - the caller sends ~crc_o).
//  Ports       : clk_i, reset_i (async, active high)
//                clear_i : reload initial value
//                en_i    : absorb d_i this cycle
//                d_i     : data byte
//                crc_o   : running CRC register
//  Revision    : 1.0 - initial release
// ============================================================================
module crc32_d8
    import eth_pkg::*;
(
    input  wire logic        clk_i,
    input  wire logic        reset_i,
    input  wire logic        clear_i,
    input  wire logic        en_i,
    input  wire logic [7:0]  d_i,
    output logic      [31:0] crc_o
);

    logic [31:0] crc_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            crc_q <= CRC32INIT;
        end else if (clear_i) begin
            crc_q <= CRC32INIT;
        end else if (en_i) begin
            crc_q <= crc32_next(crc_q, d_i);
        end
    end

    assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/eth_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : eth_tx_framer
//  Description : Ethernet transmit framer. Grants one client via request/ack,
//                buffers its payload in a small FIFO while preamble, SFD and
//                MAC header go out, then emits payload, zero pad to the
//                minimum length, CRC32 FCS and the inter-frame gap on GMII.
//  Ports       : clk_i, reset_i (async, active high)
//                bus (slave modport): request/ack, dven/data/err, smac/dmac/
//                ethertype in; txd/txen/txer GMII out; busy out
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int FIFODEPTH  = 32,
    parameter int MAXPAYLOAD = 1500,
    parameter int MINPAYLOAD = ETHMINPAYLOAD,
    parameter int IFGLEN     = 12,
    parameter int TIMEOUT    = 255
) (
    input  wire logic        clk_i,
    input  wire logic        reset_i,
    eth_tx_framer_if.slave   bus
);

    localparam int              AW        = $clog2(FIFODEPTH);
    localparam logic [AW:0]     FULL_LVL  = (AW+1)'(FIFODEPTH);
    localparam logic [AW:0]     ONE_LVL   = (AW+1)'(1);
    localparam logic [10:0]     PAY_MAX   = 11'(MAXPAYLOAD);
    localparam logic [10:0]     PAY_MIN   = 11'(MINPAYLOAD);
    localparam logic [7:0]      TOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0]      IFG_LAST  = 8'(IFGLEN - 1);
    localparam logic [7:0]      PRE_LAST  = 8'(ETHPREAMBLELEN - 1);
    localparam logic [7:0]      HDR_LAST  = 8'(ETHHEADLEN - 1);
    localparam logic [7:0]      FCS_LAST  = 8'(ETHFCSLEN - 1);

    state_e         state_q, state_d;
    logic [7:0]     step_q, step_d;
    logic [10:0]    pcnt_q, pcnt_d;
    logic [10:0]    pcnt_inc_w;
    logic [111:0]   hdr_q;
    logic           capt_q, done_q, ovf_q;
    logic [8:0]     mem_q [FIFODEPTH];
    logic [AW:0]    wptr_q, rptr_q;
    logic [AW:0]    level_w;
    logic           empty_w, full_w, want_push_w, push_w, pop_w, first_w;
    logic [8:0]     rdata_w;
    logic [7:0]     txd_d, txd_q;
    logic           txen_d, txen_q, txer_d, txer_q, ack_d, ack_q;
    logic           crc_clr_w, crc_en_w, hdr_shift_w;
    logic [31:0]    crc_w, crc_inv_w;

    // ------------------------------------------------------------------
    // Payload FIFO: {err,data} entries, pointers carry one wrap bit.
    // ------------------------------------------------------------------
    assign level_w     = wptr_q - rptr_q;
    assign empty_w     = (level_w == '0);
    assign full_w      = (level_w == FULL_LVL);
    assign first_w     = (state_q == ST_WAITDATA) && bus.dven;
    assign want_push_w = first_w || (capt_q && bus.dven);
    // A full FIFO drops the byte; the frame is then flagged via ovf_q.
    assign push_w      = want_push_w && !full_w;
    assign rdata_w     = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (push_w) begin
            mem_q[wptr_q[AW-1:0]] <= {bus.err, bus.data};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_w) wptr_q <= wptr_q + ONE_LVL;
            if (pop_w)  rptr_q <= rptr_q + ONE_LVL;
        end
    end

    // ------------------------------------------------------------------
    // Client capture: header latch, end-of-run detection, overflow flag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hdr_q  <= '0;
            capt_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && bus.request) begin
                capt_q <= 1'b0;
                done_q <= 1'b0;
                ovf_q  <= 1'b0;
            end
            if (first_w) begin
                hdr_q  <= {bus.dmac, bus.smac, bus.ethertype};
                capt_q <= 1'b1;
            end else if (hdr_shift_w) begin
                hdr_q  <= {hdr_q[103:0], 8'h00};
            end
            if (capt_q && !bus.dven) begin
                capt_q <= 1'b0;
                done_q <= 1'b1;
            end
            if (want_push_w && full_w) begin
                ovf_q  <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // CRC over header, payload and pad (exactly the bytes sent in those states).
    // ------------------------------------------------------------------
    crc32_d8 u_crc (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (crc_clr_w),
        .en_i    (crc_en_w),
        .d_i     (txd_d),
        .crc_o   (crc_w)
    );

    assign crc_inv_w  = ~crc_w;
    assign pcnt_inc_w = (pcnt_q == 11'h7FF) ? pcnt_q : (pcnt_q + 11'd1);

    // ------------------------------------------------------------------
    // Framer FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            pcnt_q  <= '0;
            txd_q   <= '0;
            txen_q  <= 1'b0;
            txer_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            pcnt_q  <= pcnt_d;
            txd_q   <= txd_d;
            txen_q  <= txen_d;
            txer_q  <= txer_d;
            ack_q   <= ack_d;
        end
    end

    // ------------------------------------------------------------------
    // Framer FSM: next state and the byte to register onto GMII
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        step_d      = step_q + 8'd1;
        pcnt_d      = pcnt_q;
        txd_d       = 8'h00;
        txen_d      = 1'b0;
        txer_d      = 1'b0;
        ack_d       = 1'b0;
        pop_w       = 1'b0;
        crc_clr_w   = 1'b0;
        crc_en_w    = 1'b0;
        hdr_shift_w = 1'b0;

        case (state_q)
            ST_IDLE: begin
                step_d = '0;
                if (bus.request) begin
                    ack_d   = 1'b1;
                    state_d = ST_WAITDATA;
                end
            end
            ST_WAITDATA: begin
                if (bus.dven) begin
                    state_d = ST_PREAMBLE;
                    step_d  = '0;
                end else if (step_q == TOUT_LAST) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                end
            end
            ST_PREAMBLE: begin
                txd_d  = ETHPREAMBLE;
                txen_d = 1'b1;
                txer_d = ovf_q;
                if (step_q == PRE_LAST) begin
                    state_d = ST_SFD;
                    step_d  = '0;
                end
            end
            ST_SFD: begin
                txd_d     = ETHSFD;
                txen_d    = 1'b1;
                txer_d    = ovf_q;
                crc_clr_w = 1'b1;
                pcnt_d    = '0;
                state_d   = ST_HEADER;
                step_d    = '0;
            end
            ST_HEADER: begin
                txd_d       = hdr_q[111:104];
                txen_d      = 1'b1;
                txer_d      = ovf_q;
                crc_en_w    = 1'b1;
                hdr_shift_w = 1'b1;
                if (step_q == HDR_LAST) begin
                    state_d = ST_PAYLOAD;
                    step_d  = '0;
                end
            end
            ST_PAYLOAD: begin
                txen_d   = 1'b1;
                crc_en_w = 1'b1;
                pcnt_d   = pcnt_inc_w;
                if (!empty_w) begin
                    pop_w  = 1'b1;
                    txd_d  = rdata_w[7:0];
                    txer_d = rdata_w[8] | ovf_q | (pcnt_inc_w > PAY_MAX);
                    // Leave on the cycle the last buffered byte goes out so
                    // txen stays continuous into pad/FCS.
                    if (level_w == ONE_LVL && done_q) begin
                        state_d = (pcnt_inc_w < PAY_MIN) ? ST_PAD : ST_FCS;
                        step_d  = '0;
                    end
                end else begin
                    // Client underrun: fill with a flagged zero byte.
                    txd_d  = 8'h00;
                    txer_d = 1'b1;
                    if (done_q) begin
                        state_d = (pcnt_inc_w < PAY_MIN) ? ST_PAD : ST_FCS;
                        step_d  = '0;
                    end
                end
            end
            ST_PAD: begin
                txd_d    = 8'h00;
                txen_d   = 1'b1;
                txer_d   = ovf_q;
                crc_en_w = 1'b1;
                pcnt_d   = pcnt_inc_w;
                if (pcnt_inc_w >= PAY_MIN) begin
                    state_d = ST_FCS;
                    step_d  = '0;
                end
            end
            ST_FCS: begin
                txen_d = 1'b1;
                txer_d = ovf_q | (pcnt_q > PAY_MAX);
                case (step_q[1:0])
                    2'd0:    txd_d = crc_inv_w[7:0];
                    2'd1:    txd_d = crc_inv_w[15:8];
                    2'd2:    txd_d = crc_inv_w[23:16];
                    default: txd_d = crc_inv_w[31:24];
                endcase
                if (step_q == FCS_LAST) begin
                    state_d = ST_IFG;
                    step_d  = '0;
                end
            end
            ST_IFG: begin
                if (step_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase
    end

    assign bus.ack  = ack_q;
    assign bus.txd  = txd_q;
    assign bus.txen = txen_q;
    assign bus.txer = txer_q;
    assign bus.busy = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_eth_tx_framer
//  Description : Directed self-checking bench for eth_tx_framer. A monitor
//                collects every txen byte; expected frames are assembled
//                from the client stimulus with an independent bitwise CRC32.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_tx_framer;

    localparam int IFGLEN = 12;
    localparam int MAXPAY = 1500;

    logic clk = 1'b0;
    logic reset;
    always #4 clk = ~clk;

    eth_tx_framer_if bus();

    eth_tx_framer #(
        .FIFODEPTH  (32),
        .MAXPAYLOAD (MAXPAY),
        .MINPAYLOAD (46),
        .IFGLEN     (IFGLEN),
        .TIMEOUT    (255)
    ) u_dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic [7:0] rx_d[$];
    logic       rx_e[$];
    int cyc = 0, last_txen_cyc = 0, ack_cyc = 0, ack_cnt = 0, frames_done = 0, txen_cnt = 0;
    logic prev_txen = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.txen === 1'b1) begin
            rx_d.push_back(bus.txd);
            rx_e.push_back(bus.txer);
            last_txen_cyc = cyc;
            txen_cnt = txen_cnt + 1;
        end
        if (prev_txen === 1'b1 && bus.txen !== 1'b1) frames_done = frames_done + 1;
        prev_txen = bus.txen;
        if (bus.ack === 1'b1) begin
            ack_cyc = cyc;
            ack_cnt = ack_cnt + 1;
        end
    end

    // ---------------- stimulus data / expected frame ----------------
    logic [7:0]  pay [0:1600];
    logic [47:0] tb_dmac = 48'h0011_2233_4455;
    logic [47:0] tb_smac = 48'h02AB_CDEF_0102;
    logic [15:0] tb_etype;
    logic [7:0]  exp_d[$];
    logic        exp_e[$];
    logic [31:0] exp_fcs;
    logic        abort = 1'b0;

    task automatic fill_pattern(input int seed);
        for (int i = 0; i <= 1600; i++) pay[i] = 8'((i * 29 + seed) ^ (i >> 3));
    endtask

    task automatic build_expected(input int len, input int errpos);
        logic [31:0] c;
        logic [7:0]  b;
        logic        fb;
        int          plen;
        exp_d.delete();
        exp_e.delete();
        for (int i = 0; i < 7; i++) begin exp_d.push_back(8'h55); exp_e.push_back(1'b0); end
        exp_d.push_back(8'hD5); exp_e.push_back(1'b0);
        for (int i = 0; i < 6; i++) begin exp_d.push_back(tb_dmac[47-8*i -: 8]); exp_e.push_back(1'b0); end
        for (int i = 0; i < 6; i++) begin exp_d.push_back(tb_smac[47-8*i -: 8]); exp_e.push_back(1'b0); end
        exp_d.push_back(tb_etype[15:8]); exp_e.push_back(1'b0);
        exp_d.push_back(tb_etype[7:0]);  exp_e.push_back(1'b0);
        for (int i = 0; i < len; i++) begin
            exp_d.push_back(pay[i]);
            exp_e.push_back((i == errpos) || (i >= MAXPAY));
        end
        plen = len;
        while (plen < 46) begin exp_d.push_back(8'h00); exp_e.push_back(1'b0); plen++; end
        c = 32'hFFFFFFFF;
        for (int k = 8; k < exp_d.size(); k++) begin
            b = exp_d[k];
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ b[j];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        exp_fcs = ~c;
        for (int j = 0; j < 4; j++) begin
            exp_d.push_back(exp_fcs[8*j +: 8]);
            exp_e.push_back(len > MAXPAY);
        end
    endtask

    task automatic compare_frame(input string tag);
        int bad_d = -1, bad_e = -1, n;
        check_val({tag, "_txen_len"}, 32'(rx_d.size()), 32'(exp_d.size()));
        n = (rx_d.size() < exp_d.size()) ? rx_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            if (bad_d < 0 && rx_d[i] !== exp_d[i]) bad_d = i;
            if (bad_e < 0 && rx_e[i] !== exp_e[i]) bad_e = i;
        end
        check_val({tag, "_first_bad_byte_idx"}, 32'(bad_d), 32'(-1));
        check_val({tag, "_first_bad_txer_idx"}, 32'(bad_e), 32'(-1));
    endtask

    // ---------------- client driver ----------------
    task automatic get_grant(input string tag, input bit hold);
        bit got = 1'b0;
        bus.request = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.ack === 1'b1) got = 1'b1;
        end
        check_val({tag, "_grant"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        if (!hold) bus.request = 1'b0;
    endtask

    task automatic send_payload(input int len, input int errpos);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            if (abort) break;
            bus.dven = 1'b1;
            bus.data = pay[i];
            bus.err  = (i == errpos);
        end
        @(posedge clk); #1;
        bus.dven = 1'b0;
        bus.data = 8'h00;
        bus.err  = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int target);
        for (int i = 0; i < 4000 && frames_done < target; i++) begin
            @(negedge clk); #1;
        end
        check_val({tag, "_frame_end"}, 32'(frames_done >= target), 32'd1);
    endtask

    task automatic run_frame(input string tag, input int len, input int errpos);
        int base = frames_done;
        rx_d.delete();
        rx_e.delete();
        build_expected(len, errpos);
        get_grant(tag, 1'b0);
        send_payload(len, errpos);
        wait_frame(tag, base + 1);
        compare_frame(tag);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [223:0] arp;
    int base, acks0, tc0, a0;

    initial begin
        bus.request   = 1'b0;
        bus.dven      = 1'b0;
        bus.data      = 8'h00;
        bus.err       = 1'b0;
        bus.smac      = tb_smac;
        bus.dmac      = tb_dmac;
        tb_etype      = 16'h0806;
        bus.ethertype = tb_etype;
        reset         = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        check_val("rst_ack",  32'(bus.ack),  32'd0);
        check_val("rst_txd",  32'(bus.txd),  32'd0);
        check_val("rst_txen", 32'(bus.txen), 32'd0);
        check_val("rst_txer", 32'(bus.txer), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;

        // ARP reply, 28 bytes: 72 txen cycles, 18 pad bytes
        arp = {16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002, tb_smac, 32'hC0A80001, tb_dmac, 32'hC0A80002};
        for (int i = 0; i < 28; i++) pay[i] = arp[223-8*i -: 8];
        run_frame("arp", 28, -1);
        check_val("arp_len72", 32'(rx_d.size()), 32'd72);
        if (rx_d.size() == 72) begin
            check_val("arp_fcs_b0", 32'(rx_d[68]), 32'(exp_fcs[7:0]));
            check_val("arp_fcs_b3", 32'(rx_d[71]), 32'(exp_fcs[31:24]));
            check_val("arp_pad_last", 32'(rx_d[67]), 32'h00);
        end
        repeat (IFGLEN + 2) @(negedge clk);
        check_val("arp_busy_after", 32'(bus.busy), 32'd0);

        // remaining frames use IPv4 ethertype and a synthetic pattern
        tb_etype      = 16'h0800;
        bus.ethertype = tb_etype;
        fill_pattern(7);

        run_frame("err5", 28, 4);
        run_frame("len1", 1, -1);
        run_frame("len46", 46, -1);
        run_frame("len60", 60, -1);
        run_frame("len1500", 1500, -1);
        run_frame("len1501", 1501, -1);

        // request held across two frames
        fill_pattern(91);
        base  = frames_done;
        acks0 = ack_cnt;
        rx_d.delete(); rx_e.delete();
        build_expected(28, -1);
        get_grant("hold1", 1'b1);
        send_payload(28, -1);
        wait_frame("hold1", base + 1);
        compare_frame("hold1");
        for (int i = 0; i < 40 && ack_cnt < acks0 + 2; i++) begin
            @(negedge clk); #1;
        end
        check_val("hold_ack_count", 32'(ack_cnt), 32'(acks0 + 2));
        check_val("hold_ack_gap", 32'(ack_cyc - last_txen_cyc), 32'(IFGLEN + 1));
        @(posedge clk); #1;
        bus.request = 1'b0;
        rx_d.delete(); rx_e.delete();
        send_payload(28, -1);
        wait_frame("hold2", base + 2);
        compare_frame("hold2");
        check_val("hold_no_extra_ack", 32'(ack_cnt), 32'(acks0 + 2));

        // grant abandoned after 255 idle cycles
        repeat (IFGLEN + 2) @(posedge clk); #1;
        tc0 = txen_cnt;
        get_grant("tout", 1'b0);
        a0 = ack_cyc;
        for (int i = 0; i < 400 && cyc < a0 + 254; i++) begin
            @(negedge clk); #1;
        end
        check_val("tout_busy_last", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check_val("tout_busy_drop", 32'(bus.busy), 32'd0);
        check_val("tout_no_txen", 32'(txen_cnt), 32'(tc0));
        run_frame("after_tout", 28, -1);

        // asynchronous reset in the middle of the payload
        repeat (IFGLEN + 2) @(posedge clk); #1;
        tc0 = txen_cnt;
        get_grant("midrst", 1'b0);
        abort = 1'b0;
        fork
            send_payload(60, -1);
            begin
                for (int i = 0; i < 400 && txen_cnt < tc0 + 40; i++) begin
                    @(negedge clk); #1;
                end
                @(posedge clk); #2;
                reset = 1'b1;
                abort = 1'b1;
                #1;
                check_val("midrst_txen", 32'(bus.txen), 32'd0);
                check_val("midrst_txer", 32'(bus.txer), 32'd0);
                check_val("midrst_busy", 32'(bus.busy), 32'd0);
                @(posedge clk);
                @(posedge clk); #1;
                reset = 1'b0;
            end
        join
        abort = 1'b0;
        repeat (2) @(posedge clk); #1;
        fill_pattern(3);
        run_frame("post_rst", 28, -1);

        repeat (IFGLEN + 2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
